// File: rtl/board_memory.sv
// Board store for the display driver: 10x40 cells, single-cell writes, multi-cycle full-row clear pass.
// Writes land one edge after sampling; wr_en/clr_start are dropped (not stalled) while busy.
module board_memory #(
  parameter int ROWS = 10,
  parameter int COLS = 40
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      wr_en,
  input  logic [3:0]                wr_row,
  input  logic [5:0]                wr_col,
  input  logic                      wr_val,
  input  logic                      clr_start,
  output logic [ROWS-1:0][COLS-1:0] boardOut,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                lines_last,
  output logic [15:0]               lines_total,
  output logic                      game_over
);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  localparam logic [3:0] ROW_LIM = 4'(ROWS);
  localparam logic [5:0] COL_LIM = 6'(COLS);
  localparam logic [3:0] R_TOP   = 4'(ROWS - 1);

  state_t      state;
  logic [3:0]  r;
  logic [16:0] total_sum;

  assign total_sum = {1'b0, lines_total} + {13'd0, lines_last};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      r           <= R_TOP;
      boardOut    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lines_last  <= '0;
      lines_total <= '0;
      game_over   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en && (wr_row < ROW_LIM) && (wr_col < COL_LIM))
            boardOut[wr_row][wr_col] <= wr_val;
          if (clr_start) begin
            state      <= SCAN;
            r          <= R_TOP;
            busy       <= 1'b1;
            lines_last <= '0;
          end
        end
        SCAN: begin
          if (&boardOut[r]) begin
            state <= SHIFT;
          end else if (r == 4'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            r <= r - 4'd1;
          end
        end
        SHIFT: begin
          // Rows at or above r drop by one; r is kept so the dropped-in row is rechecked.
          for (int i = ROWS - 1; i >= 1; i--) begin
            if (i <= int'(r))
              boardOut[i] <= boardOut[i-1];
          end
          boardOut[0] <= '0;
          lines_last  <= lines_last + 4'd1;
          state       <= SCAN;
        end
        DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          lines_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
          game_over   <= game_over | (|boardOut[0]);
          r           <= R_TOP;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_memory.sv
// Bench for board_memory: directed test-plan cases with literal expectations, then random traffic vs a pass-level model.
module tb_board_memory;

  localparam int ROWS = 10;
  localparam int COLS = 40;

  logic                      Clock;
  logic                      Reset;
  logic                      wr_en;
  logic [3:0]                wr_row;
  logic [5:0]                wr_col;
  logic                      wr_val;
  logic                      clr_start;
  logic [ROWS-1:0][COLS-1:0] boardOut;
  logic                      busy;
  logic                      done;
  logic [3:0]                lines_last;
  logic [15:0]               lines_total;
  logic                      game_over;

  board_memory #(.ROWS(ROWS), .COLS(COLS)) dut (
    .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_val(wr_val), .clr_start(clr_start), .boardOut(boardOut), .busy(busy),
    .done(done), .lines_last(lines_last), .lines_total(lines_total), .game_over(game_over)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pass-level model: a clear pass removes every full row at once and lets the rest fall.
  bit [COLS-1:0] mb   [ROWS];
  bit [COLS-1:0] pend [ROWS];
  int c = 0, plen = 0, k = 0, m_last = 0, m_total = 0;
  bit m_go = 1'b0;

  function automatic void compute_pass();
    int w;
    bit [COLS-1:0] full;
    full = '1;
    w = ROWS - 1;
    k = 0;
    for (int i = 0; i < ROWS; i++) pend[i] = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (mb[i] == full) k++;
      else begin
        pend[w] = mb[i];
        w--;
      end
    end
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < ROWS; i++) mb[i] = '0;
      c = 0; plen = 0; k = 0; m_last = 0; m_total = 0; m_go = 1'b0;
    end else if (c == 0) begin
      if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS) mb[wr_row][wr_col] = wr_val;
      if (clr_start) begin
        compute_pass();
        c = 1;
        plen = 11 + 2 * k;
        m_last = 0;
      end
    end else if (c == plen) begin
      for (int i = 0; i < ROWS; i++) mb[i] = pend[i];
      m_last = k;
      m_total = (m_total + k > 65535) ? 65535 : m_total + k;
      m_go = m_go | (pend[0] != '0);
      c = 0;
    end else begin
      c++;
    end
  end

  always @(negedge Clock) begin
    if (chk_on) begin
      check("busy", 64'(busy), 64'(c != 0));
      check("done", 64'(done), 64'(c != 0 && c == plen));
      check("lines_total", 64'(lines_total), 64'(m_total));
      check("game_over", 64'(game_over), 64'(m_go));
      if (c == 0 || c == plen) begin
        check("lines_last", 64'(lines_last), 64'(c == 0 ? m_last : k));
        for (int i = 0; i < ROWS; i++)
          check($sformatf("board_row%0d", i), 64'(boardOut[i]), 64'(c == 0 ? mb[i] : pend[i]));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic write_cell(input int row, input int col, input bit val);
    wr_en = 1'b1; wr_row = 4'(row); wr_col = 6'(col); wr_val = val;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill_row(input int row);
    for (int col = 0; col < COLS; col++) write_cell(row, col, 1'b1);
  endtask

  // Called from inside cycle n0 of a pass; returns when the pass has ended.
  task automatic wait_done(input int n0, input int exp_cyc, input string nm);
    int got;
    got = -1;
    for (int n = n0; n <= n0 + 40; n++) begin
      @(negedge Clock);
      if (done === 1'b1) begin
        got = n;
        break;
      end
      @(posedge Clock);
      #1;
    end
    @(posedge Clock);
    #1;
    check(nm, 64'(got), 64'(exp_cyc));
  endtask

  task automatic run_clear(input int exp_cyc, input string nm);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    wait_done(1, exp_cyc, nm);
  endtask

  initial begin
    Reset = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_val = 1'b0; clr_start = 1'b0;
    do_reset();
    chk_on = 1'b1;

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lines_last", 64'(lines_last), 64'd0);
    check("rst_lines_total", 64'(lines_total), 64'd0);
    check("rst_game_over", 64'(game_over), 64'd0);
    check("rst_board", 64'(|boardOut), 64'd0);

    run_clear(11, "empty_done_cycle");
    check("empty_lines_last", 64'(lines_last), 64'd0);
    check("empty_board", 64'(|boardOut), 64'd0);

    fill_row(9);
    write_cell(8, 3, 1'b1);
    run_clear(13, "one_row_done_cycle");
    check("one_row_lines_last", 64'(lines_last), 64'd1);
    check("one_row_row9", 64'(boardOut[9]), 64'h8);
    check("one_row_row8", 64'(boardOut[8]), 64'h0);

    do_reset();
    fill_row(9); fill_row(8); fill_row(6);
    write_cell(7, 0, 1'b1);
    run_clear(17, "three_rows_done_cycle");
    check("three_rows_lines_last", 64'(lines_last), 64'd3);
    check("three_rows_row9", 64'(boardOut[9]), 64'h1);
    check("three_rows_rest", 64'(|boardOut[8:0]), 64'd0);
    check("three_rows_total", 64'(lines_total), 64'd3);

    for (int row = 0; row < ROWS; row++) fill_row(row);
    run_clear(31, "all_rows_done_cycle");
    check("all_rows_lines_last", 64'(lines_last), 64'd10);
    check("all_rows_board", 64'(|boardOut), 64'd0);
    check("all_rows_total", 64'(lines_total), 64'd13);

    write_cell(0, 5, 1'b1);
    run_clear(11, "go_done_cycle");
    check("go_set", 64'(game_over), 64'd1);
    write_cell(0, 5, 1'b0);
    run_clear(11, "go_clean_done_cycle");
    check("go_sticky", 64'(game_over), 64'd1);
    do_reset();
    check("go_reset", 64'(game_over), 64'd0);

    for (int col = 0; col < COLS - 1; col++) write_cell(9, col, 1'b1);
    wr_en = 1'b1; wr_row = 4'd9; wr_col = 6'd39; wr_val = 1'b1; clr_start = 1'b1;
    tick();
    wr_en = 1'b0; clr_start = 1'b0;
    tick();
    wr_en = 1'b1; wr_row = 4'd5; wr_col = 6'd5; wr_val = 1'b1; clr_start = 1'b1;
    tick();
    wr_en = 1'b0; clr_start = 1'b0;
    wait_done(3, 13, "same_cycle_done_cycle");
    check("same_cycle_lines_last", 64'(lines_last), 64'd1);
    check("same_cycle_row9", 64'(boardOut[9]), 64'h0);
    check("busy_write_ignored", 64'(boardOut[5]), 64'h0);
    tick();
    check("busy_clr_ignored", 64'(busy), 64'd0);

    do_reset();
    fill_row(9);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_board", 64'(|boardOut), 64'd0);

    for (int it = 0; it < 600; it++) begin
      int a;
      a = int'($urandom_range(0, 99));
      if (a < 2) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
      end else if (a < 10) begin
        fill_row(int'($urandom_range(0, ROWS - 1)));
      end else begin
        wr_en     = ($urandom_range(0, 3) != 0);
        wr_row    = 4'($urandom_range(0, 11));
        wr_col    = 6'($urandom_range(0, 43));
        wr_val    = ($urandom_range(0, 7) != 0);
        clr_start = ($urandom_range(0, 9) == 0);
        tick();
        wr_en = 1'b0;
        clr_start = 1'b0;
      end
    end
    for (int n = 0; n < 40; n++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
